bin_to_bcd_converter: RTL and testbench
=======================================

# bin_to_bcd_converter

Sequential binary-to-BCD converter sitting directly downstream of the 12-bit adder stage. It takes the registered sum and converts it to four packed BCD digits for the seven-segment display driver, using an iterative shift-add-3 (double-dabble) algorithm that performs one bit per clock. It uses a start/busy/done handshake so the display path never sees a partially converted value.

## Interface
- BIN_WIDTH, 12, width of the binary input; latency equals BIN_WIDTH cycles.
- DIGITS, 4, number of BCD output digits; must satisfy 10^DIGITS > 2^BIN_WIDTH-1 (4 digits cover 0..4095).
- clk  input  1  system clock, 27 MHz.
- reset  input  1  asynchronous, active-low reset; 0 = reset asserted.
- start  input  1  conversion request; sampled on the rising edge of clk, honoured only in IDLE.
- bin_in  input  BIN_WIDTH  unsigned binary value, captured on the accepted start edge.
- bcd_out  output  4*DIGITS  packed BCD; [3:0] = units, [7:4] = tens, [11:8] = hundreds, [15:12] = thousands.
- digit_blank  output  DIGITS  per-digit leading-zero blank flags; bit i maps to BCD digit i.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when bcd_out has just been updated.
- valid  output  1  sticky; high once any conversion has completed since reset.

## Operation
- State machine has two states: IDLE and SHIFT.
- **IDLE, start=1:**
  - load shift register = {DIGITS*4 zeros, bin_in};
  - clear bit counter;
  - go to SHIFT.
- **IDLE, start=0:** hold state; all outputs hold their values.
- **SHIFT, each cycle:**
  - for every BCD nibble of the shift register that is ≥5, add 3;
  - then shift the whole register left by 1;
  - increment the counter.
- **SHIFT, on the BIN_WIDTH-th shift:**
  - register the upper DIGITS*4 bits into bcd_out;
  - update digit_blank;
  - pulse done, set valid;
  - return to IDLE.
- start asserted while in SHIFT is ignored. It is not queued.
- bin_in changes after the capture edge have no effect on the conversion in progress.
- bcd_out holds the last result until the next completion. It never shows intermediate values.
- Arithmetic is unsigned. The shift register is DIGITS*4+BIN_WIDTH bits wide. The counter is $clog2(BIN_WIDTH+1) bits wide.

## Timing
- **Reset values** (asynchronous, while reset=0):
  - state = IDLE;
  - bcd_out = 0, digit_blank = 0;
  - busy = 0, done = 0, valid = 0;
  - internal shift register and counter = 0.
- **Latency:**
  - start accepted at edge k;
  - busy = 1 after edge k;
  - bcd_out is updated, done = 1 and busy = 0 after edge k+BIN_WIDTH (edge k+12 by default).
- done is high for exactly one cycle.
- **Back-to-back:** start high in the same cycle that done is high is accepted, because the state is already IDLE. The next result appears 12 cycles later. Maximum throughput is one conversion per BIN_WIDTH+1 cycles with start held high continuously.
- **Reset mid-conversion:** aborts immediately. The FSM returns to IDLE and no done pulse is produced. After release, the block waits for a new start.
- No combinational path from any input to any output. All outputs are registered.

## Configuration
- Macro: BCD_LEADING_ZERO_BLANK_EN.
- **Defined:** on each completion, digit_blank[i] = 1 for every digit i ≥ 1 where that digit and all higher digits are zero. The units digit is never blanked.
  - Example: 457 gives digit_blank = 4'b1000.
  - Example: 0 gives digit_blank = 4'b1110.
- **Undefined:** digit_blank is held at all zeros. No blanking logic is synthesised. The port remains present.

## Test plan
- Reset low, then release; pulse start with bin_in=1347 → busy for 12 cycles; done pulse 12 cycles after the start edge; bcd_out=16'h1347; valid=1.
- bin_in=457, then bin_in=1849, each started on the cycle done goes high → bcd_out=16'h0457, then 16'h1849. Each done is exactly 12 cycles after its accepted start.
- Corner values, each a separate conversion:
  - bin_in=0 → bcd_out=16'h0000;
  - bin_in=4095 → bcd_out=16'h4095;
  - bin_in=9 → bcd_out=16'h0009;
  - bin_in=10 → bcd_out=16'h0010.
- Start pulsed again 5 cycles into a conversion of 300, with bin_in changed to 157 → start is ignored; result is 16'h0300; only one done pulse.
- Reset asserted 6 cycles into a conversion of 999 → all outputs are 0 immediately; no done pulse; the next start with 850 yields 16'h0850.
- With BCD_LEADING_ZERO_BLANK_EN defined:
  - 457 → 4'b1000;
  - 0 → 4'b1110;
  - 1000 → 4'b0000.
- Without BCD_LEADING_ZERO_BLANK_EN: digit_blank is always 4'b0000.

Source files
------------

// File: rtl/bin_to_bcd_converter.sv
// Sequential binary-to-BCD converter using shift-add-3 (double dabble), one bit per clock.
// Optional leading-zero blanking of digit_blank is enabled by defining BCD_LEADING_ZERO_BLANK_EN.
module bin_to_bcd_converter #(
  parameter int BIN_WIDTH = 12,
  parameter int DIGITS    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BIN_WIDTH-1:0]  bin_in,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     digit_blank,
  output logic                  busy,
  output logic                  done,
  output logic                  valid
);

  localparam int SR_W  = DIGITS * 4 + BIN_WIDTH;
  localparam int CNT_W = $clog2(BIN_WIDTH + 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t              state, state_d;
  logic [SR_W-1:0]     sr, sr_d, sr_adj;
  logic [CNT_W-1:0]    cnt, cnt_d;
  logic [4*DIGITS-1:0] bcd_d;
  logic                busy_d, done_d, valid_d;

`ifdef BCD_LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0]   blank_d;

  // A digit is blanked when it and every more significant digit are zero; units never blank.
  function automatic logic [DIGITS-1:0] blank_of(input logic [4*DIGITS-1:0] bcd);
    logic zero_above;
    zero_above = 1'b1;
    blank_of   = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above  = zero_above & (bcd[4*i +: 4] == 4'd0);
      blank_of[i] = zero_above;
    end
  endfunction
`endif

  // Add-3 correction on every BCD nibble sitting above the binary part of the register.
  always_comb begin
    sr_adj = sr;
    for (int i = 0; i < DIGITS; i++) begin
      if (sr[BIN_WIDTH + 4*i +: 4] >= 4'd5) begin
        sr_adj[BIN_WIDTH + 4*i +: 4] = sr[BIN_WIDTH + 4*i +: 4] + 4'd3;
      end
    end
  end

  // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state;
    sr_d    = sr;
    cnt_d   = cnt;
    bcd_d   = bcd_out;
    busy_d  = busy;
    done_d  = 1'b0;
    valid_d = valid;
`ifdef BCD_LEADING_ZERO_BLANK_EN
    blank_d = digit_blank;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          sr_d    = {{(4*DIGITS){1'b0}}, bin_in};
          cnt_d   = '0;
          state_d = SHIFT;
          busy_d  = 1'b1;
        end
      end
      SHIFT: begin
        sr_d  = sr_adj << 1;
        cnt_d = cnt + 1'b1;
        if (cnt == CNT_W'(BIN_WIDTH - 1)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          valid_d = 1'b1;
          bcd_d   = sr_d[SR_W-1 -: 4*DIGITS];
`ifdef BCD_LEADING_ZERO_BLANK_EN
          blank_d = blank_of(bcd_d);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      sr      <= '0;
      cnt     <= '0;
      bcd_out <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      valid   <= 1'b0;
    end else begin
      state   <= state_d;
      sr      <= sr_d;
      cnt     <= cnt_d;
      bcd_out <= bcd_d;
      busy    <= busy_d;
      done    <= done_d;
      valid   <= valid_d;
    end
  end

`ifdef BCD_LEADING_ZERO_BLANK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      digit_blank <= '0;
    end else begin
      digit_blank <= blank_d;
    end
  end
`else
  assign digit_blank = '0;
`endif

endmodule

// File: tb/tb_bin_to_bcd_converter.sv
// Self-checking bench for bin_to_bcd_converter: scoreboard of expected BCD/blank values,
// popped and compared on each done pulse, plus latency, handshake and reset-abort checks.
module tb_bin_to_bcd_converter;

  localparam int BW = 12;
  localparam int DG = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [BW-1:0]  bin_in;
  logic [4*DG-1:0] bcd_out;
  logic [DG-1:0]  digit_blank;
  logic           busy;
  logic           done;
  logic           valid;

  typedef struct {
    logic [4*DG-1:0] bcd;
    logic [DG-1:0]   blank;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;

  bin_to_bcd_converter #(.BIN_WIDTH(BW), .DIGITS(DG)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .bin_in      (bin_in),
    .bcd_out     (bcd_out),
    .digit_blank (digit_blank),
    .busy        (busy),
    .done        (done),
    .valid       (valid)
  );

  always #5 clk = ~clk;

  function automatic logic [4*DG-1:0] to_bcd(input int v);
    logic [4*DG-1:0] r;
    int p;
    p = 1;
    for (int i = 0; i < DG; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [DG-1:0] blank_model(input int v);
    logic [DG-1:0] r;
    int p;
    r = '0;
    p = 1;
`ifdef BCD_LEADING_ZERO_BLANK_EN
    for (int i = 1; i < DG; i++) begin
      p = p * 10;
      r[i] = (v < p);
    end
`endif
    return r;
  endfunction

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic drive_start(input int v);
    exp_t e;
    start  = 1'b1;
    bin_in = BW'(v);
    e.bcd   = to_bcd(v);
    e.blank = blank_model(v);
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts cycles after the accepting edge until done; lat = -1 if the bound expires.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset  = 1'b0;
    start  = 1'b0;
    bin_in = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bcd_out, digit_blank, busy, done, valid} !== '0)
      $display("FAIL reset_values: got bcd=%h blank=%b busy=%b done=%b valid=%b, want all 0",
               bcd_out, digit_blank, busy, done, valid);
    else passed++;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bcd_out, busy, done, valid} !== '0)
      $display("FAIL idle_hold: got bcd=%h busy=%b done=%b valid=%b, want all 0",
               bcd_out, busy, done, valid);
    else passed++;
  endtask

  task automatic test_basic;
    exp_t e;
    int   lat;
    drive_start(1347);
    checks++;
    if (busy !== 1'b1) $display("FAIL basic_busy: got %b want 1", busy);
    else passed++;
    wait_done(lat);
    e = exp_q.pop_front();
    checks++;
    if (lat !== 12) $display("FAIL basic_latency: got %0d want 12", lat);
    else passed++;
    checks++;
    if (bcd_out !== e.bcd) $display("FAIL basic_bcd: got %h want %h", bcd_out, e.bcd);
    else passed++;
    checks++;
    if (digit_blank !== e.blank) $display("FAIL basic_blank: got %b want %b", digit_blank, e.blank);
    else passed++;
    checks++;
    if ({busy, valid} !== 2'b01) $display("FAIL basic_flags: got busy=%b valid=%b want 0 1", busy, valid);
    else passed++;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || bcd_out !== e.bcd)
      $display("FAIL basic_done_pulse: got done=%b bcd=%h want 0 %h", done, bcd_out, e.bcd);
    else passed++;
  endtask

  task automatic test_back_to_back;
    exp_t e;
    int   lat;
    int   vals[2] = '{457, 1849};
    drive_start(vals[0]);
    wait_done(lat);
    for (int k = 0; k < 2; k++) begin
      e = exp_q.pop_front();
      checks++;
      if (lat !== 12) $display("FAIL b2b_latency_%0d: got %0d want 12", k, lat);
      else passed++;
      checks++;
      if (bcd_out !== e.bcd || digit_blank !== e.blank)
        $display("FAIL b2b_result_%0d: got %h/%b want %h/%b", k, bcd_out, digit_blank, e.bcd, e.blank);
      else passed++;
      if (k == 0) begin
        drive_start(vals[1]);
        wait_done(lat);
      end
    end
  endtask

  task automatic test_corners;
    exp_t e;
    int   lat;
    int   vals[7] = '{0, 4095, 9, 10, 457, 1000, 99};
    foreach (vals[k]) begin
      @(negedge clk);
      drive_start(vals[k]);
      wait_done(lat);
      e = exp_q.pop_front();
      checks++;
      if (lat !== 12 || bcd_out !== e.bcd || digit_blank !== e.blank)
        $display("FAIL corner_%0d: got lat=%0d %h/%b want lat=12 %h/%b",
                 vals[k], lat, bcd_out, digit_blank, e.bcd, e.blank);
      else passed++;
    end
  endtask

  task automatic test_ignored_start;
    exp_t e;
    int   ndone = 0;
    int   first = -1;
    @(negedge clk);
    drive_start(300);
    repeat (4) @(negedge clk);
    start  = 1'b1;
    bin_in = BW'(157);
    @(negedge clk);
    start  = 1'b0;
    for (int c = 6; c <= 40; c++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        if (first < 0) begin
          first = c;
          e = exp_q.pop_front();
          checks++;
          if (bcd_out !== e.bcd) $display("FAIL ignored_bcd: got %h want %h", bcd_out, e.bcd);
          else passed++;
        end
      end
    end
    checks++;
    if (first !== 12) $display("FAIL ignored_latency: got %0d want 12", first);
    else passed++;
    checks++;
    if (ndone !== 1) $display("FAIL ignored_done_count: got %0d want 1", ndone);
    else passed++;
  endtask

  task automatic test_reset_abort;
    exp_t e;
    int   lat;
    int   ndone = 0;
    @(negedge clk);
    drive_start(999);
    repeat (5) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if ({bcd_out, digit_blank, busy, done, valid} !== '0)
      $display("FAIL abort_values: got bcd=%h blank=%b busy=%b done=%b valid=%b, want all 0",
               bcd_out, digit_blank, busy, done, valid);
    else passed++;
    e = exp_q.pop_front();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    checks++;
    if (ndone !== 0) $display("FAIL abort_no_done: got %0d active cycles want 0", ndone);
    else passed++;
    drive_start(850);
    wait_done(lat);
    e = exp_q.pop_front();
    checks++;
    if (lat !== 12 || bcd_out !== e.bcd || digit_blank !== e.blank || valid !== 1'b1)
      $display("FAIL abort_restart: got lat=%0d %h/%b valid=%b want lat=12 %h/%b valid=1",
               lat, bcd_out, digit_blank, valid, e.bcd, e.blank);
    else passed++;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_back_to_back;
    test_corners;
    test_ignored_start;
    test_reset_abort;
    checks++;
    if (exp_q.size() !== 0) $display("FAIL scoreboard_empty: got %0d entries want 0", exp_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
